// File: rtl/gaussian_filter_accel_pkg.sv
// Shared definitions for the Gaussian filter accelerator divider.
//   DIV_W / DVS_W : default dividend (quotient) and divisor (remainder) widths
//   CNT_W         : iteration counter width for the default dividend width
//   state_t       : divider control states
package gaussian_filter_accel_pkg;

  localparam int DIV_W = 32;
  localparam int DVS_W = 16;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gaussian_filter_accel_udiv_step.sv
// One combinational iteration of an unsigned restoring divider.
// Ports:
//   rem_i     : partial remainder entering the iteration (DIVISOR_W+1 bits)
//   bit_i     : next dividend bit, shifted into the remainder LSB
//   divisor_i : divisor
//   rem_o     : partial remainder after the trial subtraction
//   q_o       : quotient bit produced by this iteration
module gaussian_filter_accel_udiv_step
  import gaussian_filter_accel_pkg::*;
#(
  parameter int DIVISOR_W = DVS_W
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  localparam int RW = DIVISOR_W + 1;

  logic [DIVISOR_W+1:0] shifted;
  logic                 no_borrow;

  // The incoming remainder is always below the divisor, so after the shift
  // the result fits back into DIVISOR_W+1 bits whichever branch is taken.
  assign shifted   = {rem_i, bit_i};
  assign no_borrow = (shifted >= {2'b00, divisor_i});
  assign rem_o     = no_borrow ? RW'(shifted - {2'b00, divisor_i}) : RW'(shifted);
  assign q_o       = no_borrow;

endmodule

// File: rtl/gaussian_filter_accel_udiv_32ns_16ns_seq.sv
// Sequential unsigned radix-2 restoring divider that normalises the Gaussian
// weighted sum by the kernel weight sum. One quotient bit per enabled cycle,
// optional half-up rounding with saturation, valid/ready on both sides.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   ce                     : clock enable; 0 freezes all state and both handshakes
//   in_valid / in_ready    : operand handshake (dividend, divisor)
//   out_valid / out_ready  : result handshake (quotient, remainder, div_by_zero)
module gaussian_filter_accel_udiv_32ns_16ns_seq
  import gaussian_filter_accel_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_W,
  parameter int DIVISOR_W  = DVS_W,
  parameter bit ROUND      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_W);

  // Control and result registers
  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  dbz_q;

  // Working datapath: dvd_q shifts dividend bits out of its MSB while
  // quotient bits fill in from its LSB, so after DIVIDEND_W iterations it
  // holds the raw quotient.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVIDEND_W-1:0] dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W:0]    prem_q;
  logic [DIVISOR_W:0]    prem_d;
  logic                  qbit;

  logic                  in_xfer;
  logic                  out_xfer;

  // Half-up rounding of the final quotient; never wraps past all-ones.
  function automatic logic [DIVIDEND_W-1:0] round_quo(
    input logic [DIVIDEND_W-1:0] q,
    input logic [DIVISOR_W:0]    r,
    input logic [DIVISOR_W-1:0]  d
  );
    logic [DIVISOR_W+1:0] twice_r;
    twice_r = {r, 1'b0};
    if (ROUND && (twice_r >= {2'b00, d}) && !(&q)) begin
      return q + {{(DIVIDEND_W-1){1'b0}}, 1'b1};
    end
    return q;
  endfunction

  gaussian_filter_accel_udiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (prem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (prem_d),
    .q_o       (qbit)
  );

  assign dvd_d    = {dvd_q[DIVIDEND_W-2:0], qbit};
  assign in_xfer  = ce & in_valid & in_ready_q;
  assign out_xfer = ce & out_valid_q & out_ready;

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (in_xfer) begin
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              // Divide-by-zero skips the iterations entirely.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              quo_q       <= '1;
              rem_q       <= dividend[DIVISOR_W-1:0];
              dbz_q       <= 1'b1;
            end else begin
              state_q <= CALC;
              cnt_q   <= CW'(DIVIDEND_W - 1);
            end
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            // Final iteration: results are taken straight from the step
            // outputs so no extra cycle is spent on rounding.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            quo_q       <= round_quo(dvd_d, prem_d, dvs_q);
            rem_q       <= DIVISOR_W'(prem_d);
            dbz_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_xfer) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Iteration datapath; contents are only meaningful between load and DONE,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      dvd_q  <= dividend;
      dvs_q  <= divisor;
      prem_q <= '0;
    end else if (ce && (state_q == CALC)) begin
      dvd_q  <= dvd_d;
      prem_q <= prem_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gaussian_filter_accel_udiv_32ns_16ns_seq.sv
// Bench for the sequential divider: a truncating and a rounding instance
// share one stimulus stream.
module tb_gaussian_filter_accel_udiv_32ns_16ns_seq;

  localparam int NRAND  = 2000;
  localparam int BUDGET = 95000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;

  logic        in_ready_t, out_valid_t, dbz_t;
  logic [31:0] quotient_t;
  logic [15:0] remainder_t;
  logic        in_ready_r, out_valid_r, dbz_r;
  logic [31:0] quotient_r;
  logic [15:0] remainder_r;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gaussian_filter_accel_udiv_32ns_16ns_seq #(
    .DIVIDEND_W (32), .DIVISOR_W (16), .ROUND (1'b0)
  ) u_trn (
    .clk (clk), .rst_n (rst_n), .ce (ce),
    .in_valid (in_valid), .in_ready (in_ready_t),
    .dividend (dividend), .divisor (divisor),
    .out_valid (out_valid_t), .out_ready (out_ready),
    .quotient (quotient_t), .remainder (remainder_t), .div_by_zero (dbz_t)
  );

  gaussian_filter_accel_udiv_32ns_16ns_seq #(
    .DIVIDEND_W (32), .DIVISOR_W (16), .ROUND (1'b1)
  ) u_rnd (
    .clk (clk), .rst_n (rst_n), .ce (ce),
    .in_valid (in_valid), .in_ready (in_ready_r),
    .dividend (dividend), .divisor (divisor),
    .out_valid (out_valid_r), .out_ready (out_ready),
    .quotient (quotient_r), .remainder (remainder_r), .div_by_zero (dbz_r)
  );

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] qt;
    logic [31:0] qr;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
  } pair_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, half-up rounding clamped to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [15:0] b, input bit rnd,
                                output logic [31:0] q, output logic [15:0] r, output logic dbz);
    longint unsigned qq, rr;
    if (b == 16'h0) begin
      q = 32'hFFFF_FFFF;
      r = a[15:0];
      dbz = 1'b1;
    end else begin
      qq = longint'(a) / longint'(b);
      rr = longint'(a) % longint'(b);
      if (rnd && (2 * rr >= longint'(b))) qq = qq + 1;
      if (qq > 64'hFFFF_FFFF) qq = 64'hFFFF_FFFF;
      q = 32'(qq);
      r = 16'(rr);
      dbz = 1'b0;
    end
  endfunction

  // Waits for in_ready, transfers one operand pair, then counts ce-enabled
  // edges (the transfer edge being the first) until out_valid.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, output int lat, output logic ok);
    int g;
    g = 0;
    ce = 1'b1;
    while (!in_ready_t && g < 100) begin
      tick();
      g++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_t && lat < 200) begin
      tick();
      lat++;
    end
    ok = out_valid_t;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t        tbl[12];
  pair_t       pq[$];
  pair_t       p;
  int          lat;
  logic        ok;
  logic        seen;
  logic [31:0] eq;
  logic [15:0] er;
  logic        ed;
  int          accepted, results, cyc;
  int          bsel;

  initial begin
    tbl[0]  = '{32'd100,        16'd7,      32'd14,         32'd14,         16'd2,      1'b0, 33};
    tbl[1]  = '{32'd100,        16'd8,      32'd12,         32'd13,         16'd4,      1'b0, 33};
    tbl[2]  = '{32'd99,         16'd10,     32'd9,          32'd10,         16'd9,      1'b0, 33};
    // 0x7FFFFFFF remainder 1 rounds half-up to 0x80000000.
    tbl[3]  = '{32'hFFFF_FFFF,  16'd2,      32'h7FFF_FFFF,  32'h8000_0000,  16'd1,      1'b0, 33};
    tbl[4]  = '{32'd1234,       16'd0,      32'hFFFF_FFFF,  32'hFFFF_FFFF,  16'h04D2,   1'b1, 1};
    tbl[5]  = '{32'd5,          16'd5,      32'd1,          32'd1,          16'd0,      1'b0, 33};
    tbl[6]  = '{32'hDEAD_BEEF,  16'h1234,   32'h000C_3BA5,  32'h000C_3BA5,  16'h076B,   1'b0, 33};
    tbl[7]  = '{32'd3,          16'd10,     32'd0,          32'd0,          16'd3,      1'b0, 33};
    tbl[8]  = '{32'd7,          16'd10,     32'd0,          32'd1,          16'd7,      1'b0, 33};
    tbl[9]  = '{32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  32'hFFFF_FFFF,  16'd0,      1'b0, 33};
    tbl[10] = '{32'd0,          16'd5,      32'd0,          32'd0,          16'd0,      1'b0, 33};
    tbl[11] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  32'h0001_0001,  16'd0,      1'b0, 33};

    // Reset state
    ce = 1'b1;
    tick(); tick(); tick();
    chk("rst_in_ready",  32'(in_ready_t),  32'd1);
    chk("rst_out_valid", 32'(out_valid_t), 32'd0);
    chk("rst_quotient",  quotient_t,       32'd0);
    chk("rst_remainder", 32'(remainder_t), 32'd0);
    chk("rst_dbz",       32'(dbz_t),       32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready_r), 32'd1);

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].a, tbl[i].b, lat, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_q_trunc", i), quotient_t, tbl[i].qt);
      chk($sformatf("v%0d_q_round", i), quotient_r, tbl[i].qr);
      chk($sformatf("v%0d_r_trunc", i), 32'(remainder_t), 32'(tbl[i].r));
      chk($sformatf("v%0d_r_round", i), 32'(remainder_r), 32'(tbl[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(dbz_t), 32'(tbl[i].dbz));
      chk($sformatf("v%0d_dbz_r", i), 32'(dbz_r), 32'(tbl[i].dbz));
      chk($sformatf("v%0d_in_ready_done", i), 32'(in_ready_t), 32'd0);
      take();
    end

    // Backpressure in DONE, then a pending input while the output drains
    do_op(32'd100, 16'd7, lat, ok);
    chk("bp_done", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_q", quotient_t, 32'd14);
      chk("bp_r", 32'(remainder_t), 32'd2);
      chk("bp_out_valid", 32'(out_valid_t), 32'd1);
      chk("bp_in_ready", 32'(in_ready_t), 32'd0);
    end
    dividend  = 32'd5;
    divisor   = 16'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("both_out_valid", 32'(out_valid_t), 32'd0);
    chk("both_in_ready", 32'(in_ready_t), 32'd1);
    chk("idle_q_held", quotient_t, 32'd14);
    tick();
    in_valid = 1'b0;
    chk("both_accept_late", 32'(in_ready_t), 32'd0);
    lat = 1;
    while (!out_valid_t && lat < 200) begin
      tick();
      lat++;
    end
    chk("both_lat", 32'(lat), 32'd33);
    chk("both_q", quotient_t, 32'd1);
    take();

    // ce toggling during CALC doubles latency
    do_op(32'd99, 16'd10, lat, ok);
    take();
    dividend = 32'd99;
    divisor  = 16'd10;
    in_valid = 1'b1;
    ce = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_t && lat < 300) begin
      ce = ~ce;
      tick();
      lat++;
    end
    chk("ce_lat", 32'(lat), 32'd65);
    chk("ce_q_trunc", quotient_t, 32'd9);
    chk("ce_q_round", quotient_r, 32'd10);
    chk("ce_r", 32'(remainder_t), 32'd9);
    ce = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ce_blocks_out", 32'(out_valid_t), 32'd1);
    ce = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ce_out_taken", 32'(out_valid_t), 32'd0);

    // Reset in the middle of CALC
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready_t), 32'd1);
    chk("midrst_out_valid", 32'(out_valid_t), 32'd0);
    chk("midrst_quotient", quotient_t, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready_next", 32'(in_ready_t), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid_t || out_valid_r) seen = 1'b1;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    do_op(32'hDEAD_BEEF, 16'h1234, lat, ok);
    chk("midrst_redo_lat", 32'(lat), 32'd33);
    chk("midrst_redo_q", quotient_t, 32'h000C_3BA5);
    chk("midrst_redo_r", 32'(remainder_t), 32'h076B);
    take();

    // Randomized traffic against the reference model
    accepted = 0;
    results  = 0;
    cyc      = 0;
    while ((accepted < NRAND || pq.size() != 0) && cyc < BUDGET) begin
      ce        = ($urandom_range(15) != 0);
      in_valid  = (accepted < NRAND) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      bsel = $urandom_range(7);
      if (bsel == 0)      divisor = 16'h0;
      else if (bsel < 3)  divisor = 16'($urandom_range(15, 1));
      else                divisor = 16'($urandom);
      if ($urandom_range(3) == 0) dividend = 32'($urandom_range(1000));
      else                        dividend = $urandom;
      if (ce && out_valid_t && out_ready) begin
        if (pq.size() == 0) begin
          chk("rand_extra_result", 32'(out_valid_t), 32'd0);
        end else begin
          p = pq.pop_front();
          results++;
          model(p.a, p.b, 1'b0, eq, er, ed);
          chk("rand_q_trunc", quotient_t, eq);
          chk("rand_r_trunc", 32'(remainder_t), 32'(er));
          chk("rand_dbz", 32'(dbz_t), 32'(ed));
          model(p.a, p.b, 1'b1, eq, er, ed);
          chk("rand_q_round", quotient_r, eq);
          chk("rand_r_round", 32'(remainder_r), 32'(er));
          chk("rand_vld_round", 32'(out_valid_r), 32'd1);
        end
      end
      if (ce && in_valid && in_ready_t) begin
        pq.push_back('{dividend, divisor});
        accepted++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_within_budget", 32'(cyc < BUDGET), 32'd1);
    chk("rand_result_count", 32'(results), 32'(NRAND));
    chk("rand_queue_empty", 32'(pq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
